// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator. The system clock is divided by two to give
//   the pixel rate; x/y counters sweep the full raster, and two phase FSMs
//   (horizontal and vertical) track sync / back porch / active / front porch.
//   The sync and blank outputs are decoded from FSM state registers that
//   change on the same edge as the counters, so all outputs line up with x/y.
//
// Ports
//   clk         in   system clock (50 MHz nominal), only clock in the block
//   rst_n       in   asynchronous active-low reset
//   x           out  horizontal counter, 0..H_TOTAL-1
//   y           out  vertical counter, 0..V_TOTAL-1
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   vga_clk     out  pixel clock to the DAC (clk / 2)
//   blank_n     out  high only inside the visible window
//   sync_n      out  composite sync, unused, constant 0
//   pix_tick    out  one-clk pulse on each pixel advance
//   frame_start out  one-clk pulse in the cycle the counters show (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_clk,
  output logic       blank_n,
  output logic       sync_n,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Last counter value of each phase; a phase FSM leaves its state on the
  // tick edge that moves the counter past this value.
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BACK_LAST = 10'(H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BACK_LAST = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {HSYNC, HBACK, HACT, HFRONT} h_state_e;
  typedef enum logic [1:0] {VSYNC, VBACK, VACT, VFRONT} v_state_e;

  logic       tog_q, tog_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       frame_start_q, frame_start_d;
  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;

  logic x_end, y_end, line_adv;

  assign pix_tick = tog_q;
  assign x_end    = (x_q == H_LAST);
  assign y_end    = (y_q == V_LAST);
  // The vertical side moves only on the tick that ends a line.
  assign line_adv = pix_tick && x_end;

  // Counters: compare against the last value before incrementing so the
  // count never passes through H_TOTAL / V_TOTAL.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that left
    // one unassigned would infer a latch.
    tog_d         = ~tog_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = line_adv && y_end;
    if (pix_tick) begin
      x_d = x_end ? 10'd0 : x_q + 10'd1;
    end
    if (line_adv) begin
      y_d = y_end ? 10'd0 : y_q + 10'd1;
    end
  end

  // Horizontal phase FSM: transitions on the tick whose x is the last value
  // of the current phase, i.e. the same edge on which x enters the next one.
  always_comb begin
    h_state_d = h_state_q;
    if (pix_tick) begin
      unique case (h_state_q)
        HSYNC:  if (x_q == H_SYNC_LAST) h_state_d = HBACK;
        HBACK:  if (x_q == H_BACK_LAST) h_state_d = HACT;
        HACT:   if (x_q == H_ACT_LAST)  h_state_d = HFRONT;
        HFRONT: if (x_end)              h_state_d = HSYNC;
        default:                        h_state_d = HSYNC;
      endcase
    end
  end

  // Vertical phase FSM, same structure, stepped once per line.
  always_comb begin
    v_state_d = v_state_q;
    if (line_adv) begin
      unique case (v_state_q)
        VSYNC:  if (y_q == V_SYNC_LAST) v_state_d = VBACK;
        VBACK:  if (y_q == V_BACK_LAST) v_state_d = VACT;
        VACT:   if (y_q == V_ACT_LAST)  v_state_d = VFRONT;
        VFRONT: if (y_end)              v_state_d = VSYNC;
        default:                        v_state_d = VSYNC;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q         <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      frame_start_q <= 1'b0;
      h_state_q     <= HSYNC;
      v_state_q     <= VSYNC;
    end else begin
      tog_q         <= tog_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign vga_clk     = tog_q;
  assign hsync       = (h_state_q != HSYNC);
  assign vsync       = (v_state_q != VSYNC);
  assign blank_n     = (h_state_q == HACT) && (v_state_q == VACT);
  assign sync_n      = 1'b0;
  assign frame_start = frame_start_q;

endmodule
